// File: rtl/riscv_id_ex_stage_pkg.sv
// Shared defaults and ALU opcode encodings for the ID/EX stage and riscv_alu.
package riscv_id_ex_stage_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
endpackage

// File: rtl/riscv_id_ex_stage_fwd.sv
// Per-source forwarding mux: EX/MEM beats MEM/WB, x0 never forwards.
module riscv_fwd_sel
  import riscv_id_ex_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [XLEN-1:0]   raw,
  input  logic              exm_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   data
);
  always_comb begin
    data = raw;
    if (addr != '0) begin
      if (exm_en && exm_rd == addr)     data = exm_data;
      else if (wb_en && wb_rd == addr)  data = wb_data;
    end
  end
endmodule

// File: rtl/riscv_id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake and operand forwarding
// both at capture and while the entry is held by a downstream stall.
module riscv_id_ex_stage
  import riscv_id_ex_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [3:0]        in_alu_op,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic              in_use_pc,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              exm_fwd_en,
  input  logic [REG_AW-1:0] exm_fwd_rd,
  input  logic [XLEN-1:0]   exm_fwd_data,
  input  logic              wb_fwd_en,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_opcode,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_reg_write,
  output logic [XLEN-1:0]   out_store_data,
  output logic [XLEN-1:0]   out_pc
);
  logic              vld_q;
  logic [3:0]        op_q;
  logic [XLEN-1:0]   pc_q, imm_q, rs1_val_q, rs2_val_q;
  logic [REG_AW-1:0] rs1_addr_q, rs2_addr_q, rd_q;
  logic              use_imm_q, use_pc_q, reg_write_q;

  logic [XLEN-1:0]   cap_rs1, cap_rs2, ref_rs1, ref_rs2;
  logic              capture, hold;

  assign in_ready = !vld_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign hold     = vld_q && !out_ready && !flush;

  riscv_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_cap_rs1 (
    .addr(in_rs1_addr), .raw(in_rs1_data),
    .exm_en(exm_fwd_en), .exm_rd(exm_fwd_rd), .exm_data(exm_fwd_data),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .data(cap_rs1));
  riscv_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_cap_rs2 (
    .addr(in_rs2_addr), .raw(in_rs2_data),
    .exm_en(exm_fwd_en), .exm_rd(exm_fwd_rd), .exm_data(exm_fwd_data),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .data(cap_rs2));
  // Refresh path re-forwards the held operands so a producer retiring mid-stall is picked up.
  riscv_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_ref_rs1 (
    .addr(rs1_addr_q), .raw(rs1_val_q),
    .exm_en(exm_fwd_en), .exm_rd(exm_fwd_rd), .exm_data(exm_fwd_data),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .data(ref_rs1));
  riscv_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_ref_rs2 (
    .addr(rs2_addr_q), .raw(rs2_val_q),
    .exm_en(exm_fwd_en), .exm_rd(exm_fwd_rd), .exm_data(exm_fwd_data),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .data(ref_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          vld_q <= 1'b0;
    else if (flush)      vld_q <= 1'b0;
    else if (capture)    vld_q <= 1'b1;
    else if (out_ready)  vld_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= ALU_ADD;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      use_imm_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (capture) begin
      op_q        <= in_alu_op;
      pc_q        <= in_pc;
      imm_q       <= in_imm;
      rs1_val_q   <= cap_rs1;
      rs2_val_q   <= cap_rs2;
      rs1_addr_q  <= in_rs1_addr;
      rs2_addr_q  <= in_rs2_addr;
      rd_q        <= in_rd_addr;
      use_imm_q   <= in_use_imm;
      use_pc_q    <= in_use_pc;
      reg_write_q <= in_reg_write;
    end else if (hold) begin
      rs1_val_q   <= ref_rs1;
      rs2_val_q   <= ref_rs2;
    end
  end

  assign out_valid      = vld_q;
  assign alu_opcode     = op_q;
  assign alu_a          = use_pc_q  ? pc_q  : rs1_val_q;
  assign alu_b          = use_imm_q ? imm_q : rs2_val_q;
  assign out_store_data = rs2_val_q;
  assign out_rd_addr    = rd_q;
  assign out_reg_write  = reg_write_q;
  assign out_pc         = pc_q;
endmodule

// File: tb/tb_riscv_id_ex_stage.sv
// Directed bench for riscv_id_ex_stage: capture, forwarding priority, stall refresh,
// throughput, flush and asynchronous reset.
module tb_riscv_id_ex_stage;
  import riscv_id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm, in_use_pc, in_reg_write, flush;
  logic        exm_fwd_en, wb_fwd_en;
  logic [4:0]  exm_fwd_rd, wb_fwd_rd;
  logic [31:0] exm_fwd_data, wb_fwd_data;
  logic        out_valid, out_ready;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, out_store_data, out_pc;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_alu_op(in_alu_op),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .in_reg_write(in_reg_write),
    .flush(flush),
    .exm_fwd_en(exm_fwd_en), .exm_fwd_rd(exm_fwd_rd), .exm_fwd_data(exm_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .out_store_data(out_store_data), .out_pc(out_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1ns after it; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; in_pc = '0; in_alu_op = ALU_ADD;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_use_imm = 0; in_use_pc = 0; in_reg_write = 0; flush = 0;
    exm_fwd_en = 0; exm_fwd_rd = '0; exm_fwd_data = '0;
    wb_fwd_en = 0; wb_fwd_rd = '0; wb_fwd_data = '0;
    out_ready = 1;

    // Reset state
    step();
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_op",      32'(alu_opcode), 32'(ALU_ADD));
    chk("rst_a",       alu_a, 32'd0);
    chk("rst_b",       alu_b, 32'd0);
    chk("rst_sd",      out_store_data, 32'd0);
    chk("rst_pc",      out_pc, 32'd0);
    chk("rst_rd",      32'(out_rd_addr), 32'd0);
    chk("rst_wr",      32'(out_reg_write), 32'd0);
    chk("rst_inready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Simple capture with immediate
    in_valid = 1; in_pc = 32'h100; in_alu_op = ALU_ADD;
    in_rs1_addr = 5'd1; in_rs2_addr = 5'd2; in_rd_addr = 5'd5;
    in_rs1_data = 32'd5; in_rs2_data = 32'd9; in_imm = 32'd7;
    in_use_imm = 1; in_reg_write = 1;
    step();
    in_valid = 0;
    chk("cap_valid", 32'(out_valid), 32'd1);
    chk("cap_a",     alu_a, 32'd5);
    chk("cap_b",     alu_b, 32'd7);
    chk("cap_sd",    out_store_data, 32'd9);
    chk("cap_rd",    32'(out_rd_addr), 32'd5);
    chk("cap_wr",    32'(out_reg_write), 32'd1);
    chk("cap_pc",    out_pc, 32'h100);
    step();
    chk("depart_valid", 32'(out_valid), 32'd0);

    // EX/MEM beats MEM/WB on the same register
    in_valid = 1; in_alu_op = ALU_SUB; in_use_imm = 0;
    in_rs1_addr = 5'd3; in_rs1_data = 32'h11; in_rs2_addr = 5'd0; in_rs2_data = 32'h22;
    exm_fwd_en = 1; exm_fwd_rd = 5'd3; exm_fwd_data = 32'hAA;
    wb_fwd_en  = 1; wb_fwd_rd  = 5'd3; wb_fwd_data  = 32'hBB;
    step();
    in_valid = 0; exm_fwd_en = 0; wb_fwd_en = 0;
    chk("prio_a",  alu_a, 32'hAA);
    chk("prio_b",  alu_b, 32'h22);
    chk("prio_op", 32'(alu_opcode), 32'(ALU_SUB));
    step();

    // x0 never forwards; MEM/WB alone forwards on rs2
    in_valid = 1; in_rs1_addr = 5'd0; in_rs1_data = 32'h33;
    in_rs2_addr = 5'd6; in_rs2_data = 32'h44;
    exm_fwd_en = 1; exm_fwd_rd = 5'd0; exm_fwd_data = 32'hCC;
    wb_fwd_en  = 1; wb_fwd_rd  = 5'd6; wb_fwd_data  = 32'h66;
    step();
    in_valid = 0; exm_fwd_en = 0; wb_fwd_en = 0;
    chk("x0_a",  alu_a, 32'h33);
    chk("wb_b",  alu_b, 32'h66);
    step();

    // Stall refresh: producer of x4 retires during the stall
    in_valid = 1; out_ready = 0; in_rs1_addr = 5'd1; in_rs1_data = 32'd1;
    in_rs2_addr = 5'd4; in_rs2_data = 32'h55;
    step();
    in_valid = 0;
    chk("stall1_sd",    out_store_data, 32'h55);
    chk("stall1_ready", 32'(in_ready), 32'd0);
    wb_fwd_en = 1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'h1234;
    chk("stall2_sd",    out_store_data, 32'h55);
    step();
    wb_fwd_en = 0;
    chk("stall3_sd",    out_store_data, 32'h1234);
    chk("stall3_b",     alu_b, 32'h1234);
    chk("stall3_a",     alu_a, 32'd1);
    step();
    chk("stall4_sd",    out_store_data, 32'h1234);
    chk("stall4_valid", 32'(out_valid), 32'd1);
    out_ready = 1;
    step();
    chk("stall_depart", 32'(out_valid), 32'd0);

    // Async reset while an entry is held
    in_valid = 1; out_ready = 0; in_alu_op = ALU_XOR;
    step();
    in_valid = 0;
    chk("pre_rst_op", 32'(alu_opcode), 32'(ALU_XOR));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_op",    32'(alu_opcode), 32'(ALU_ADD));
    #1;
    rst_n = 1'b1;
    out_ready = 1;
    step();

    // Throughput: four back-to-back entries
    in_valid = 1; in_alu_op = ALU_OR; in_rs1_addr = 5'd7; in_use_imm = 0; in_use_pc = 0;
    for (int i = 0; i < 4; i++) begin
      in_rs1_data = 32'd10 + 32'(i);
      chk($sformatf("tput_ready%0d", i), 32'(in_ready), 32'd1);
      step();
      chk($sformatf("tput_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("tput_a%0d", i), alu_a, 32'd10 + 32'(i));
    end
    in_valid = 0;
    step();
    chk("tput_drain", 32'(out_valid), 32'd0);

    // Flush beats a pending capture
    in_valid = 1; out_ready = 0; in_use_pc = 1; in_pc = 32'h200; in_rs1_data = 32'h77;
    step();
    chk("fl_hold_a", alu_a, 32'h200);
    in_use_pc = 0; in_pc = 32'h300; in_rs1_data = 32'h99; flush = 1;
    chk("fl_ready_indep", 32'(in_ready), 32'd0);
    step();
    flush = 0; in_valid = 0;
    chk("fl_valid",  32'(out_valid), 32'd0);
    chk("fl_keep_a", alu_a, 32'h200);
    chk("fl_keep_pc", out_pc, 32'h200);
    out_ready = 1;
    step();
    chk("fl_nocap", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
